// File: rtl/branch_resolve_if.sv
// branch_resolve_if: control-transfer request, redirect handshake and statistics bundle for branch_resolve
interface branch_resolve_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       br_type;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1;
    logic             eq_flag;
    logic             less_flag;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             redir_valid;
    logic             redir_ready;
    logic [XLEN-1:0]  redir_pc;
    logic             flush;
    logic             wb_valid;
    logic [XLEN-1:0]  wb_link;
    logic             misalign;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    modport slave (
        input  in_valid, br_type, funct3, pc, imm, rs1, eq_flag, less_flag,
               pred_taken, pred_target, redir_ready,
        output in_ready, redir_valid, redir_pc, flush, wb_valid, wb_link,
               misalign, br_cnt, mis_cnt
    );

    modport master (
        output in_valid, br_type, funct3, pc, imm, rs1, eq_flag, less_flag,
               pred_taken, pred_target, redir_ready,
        input  in_ready, redir_valid, redir_pc, flush, wb_valid, wb_link,
               misalign, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch/jump resolution with redirect handshake and saturating statistics
module branch_resolve #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input logic            clock,
    input logic            reset,
    branch_resolve_if.slave bus
);
    typedef enum logic {RUN, REDIR} state_t;

    state_t           state, state_nx;
    logic             accept, active, is_jump, cond, taken, mal, mispred, redirect;
    logic [XLEN-1:0]  target, link, next_pc;
    logic [XLEN-1:0]  redir_pc_q, wb_link_q;
    logic             wb_valid_q, misalign_q;
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

    // Resolve the presented instruction and decide the next FSM state
    always_comb begin
        state_nx = state;
        accept   = bus.in_valid && state == RUN;
        active   = accept && bus.br_type != 2'b11;
        is_jump  = bus.br_type == 2'b01 || bus.br_type == 2'b10;
        cond     = bus.funct3[2] ? (bus.less_flag ^ bus.funct3[0])
                 : (bus.funct3[1] ? 1'b0 : (bus.eq_flag ^ bus.funct3[0]));
        taken    = bus.br_type == 2'b00 ? cond : bus.br_type != 2'b11;
        target   = bus.br_type == 2'b10 ? ((bus.rs1 + bus.imm) & ~XLEN'(1)) : bus.pc + bus.imm;
        link     = bus.pc + XLEN'(4);
        next_pc  = taken ? target : link;
        mal      = taken && target[1];
        mispred  = (taken != bus.pred_taken) || (taken && target != bus.pred_target);
        redirect = active && mispred && !mal;
        if (state == RUN && redirect)
            state_nx = REDIR;
        else if (state == REDIR && bus.redir_ready)
            state_nx = RUN;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset)
            state <= RUN;
        else
            state <= state_nx;
    end

    // Redirect target, link result, pulses and saturating counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            redir_pc_q <= '0;
            wb_link_q  <= '0;
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
        end else begin
            wb_valid_q <= active && is_jump;
            misalign_q <= active && mal;
            if (redirect)
                redir_pc_q <= next_pc;
            if (active && is_jump)
                wb_link_q <= link;
            br_cnt_q  <= br_cnt_q + CNT_W'(active && !(&br_cnt_q));
            mis_cnt_q <= mis_cnt_q + CNT_W'(active && (mispred || mal) && !(&mis_cnt_q));
        end
    end

    assign bus.in_ready    = state == RUN;
    assign bus.redir_valid = state == REDIR;
    assign bus.flush       = state == REDIR && bus.redir_ready;
    assign bus.redir_pc    = redir_pc_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_link     = wb_link_q;
    assign bus.misalign    = misalign_q;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.mis_cnt     = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: table-driven scoreboard bench for branch_resolve
module tb_branch_resolve;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    branch_resolve_if bus ();
    branch_resolve dut (.clock(clock), .reset(reset), .bus(bus));

    branch_resolve_if #(.CNT_W(2)) sb ();
    branch_resolve #(.CNT_W(2)) sdut (.clock(clock), .reset(reset), .bus(sb));

    typedef struct {
        logic [1:0]  bt;
        logic [2:0]  f3;
        logic [63:0] pc, imm, rs1;
        logic        eq, lt, pt;
        logic [63:0] ptgt;
        int          hold;
        logic        e_redir;
        logic [63:0] e_rpc;
        logic        e_wb;
        logic [63:0] e_link;
        logic        e_mal;
    } vec_t;

    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        logic        wb;
        logic [63:0] link;
        logic        mal;
        int          hold;
        logic        cnt_br;
    } exp_t;

    localparam int NV = 13;
    vec_t v [NV];
    exp_t sbq [$];
    int n_chk = 0;
    int n_fail = 0;
    int exp_br = 0;
    int exp_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic drive(input vec_t x);
        exp_t e;
        chk("in_ready_at_drive", 64'(bus.in_ready), 64'd1);
        bus.in_valid    = 1'b1;
        bus.br_type     = x.bt;
        bus.funct3      = x.f3;
        bus.pc          = x.pc;
        bus.imm         = x.imm;
        bus.rs1         = x.rs1;
        bus.eq_flag     = x.eq;
        bus.less_flag   = x.lt;
        bus.pred_taken  = x.pt;
        bus.pred_target = x.ptgt;
        e.redir  = x.e_redir;
        e.rpc    = x.e_rpc;
        e.wb     = x.e_wb;
        e.link   = x.e_link;
        e.mal    = x.e_mal;
        e.hold   = x.hold;
        e.cnt_br = x.bt != 2'b11;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sbq.pop_front();
        exp_br  += int'(e.cnt_br);
        exp_mis += int'(e.redir || e.mal);
        chk("redir_valid", 64'(bus.redir_valid), 64'(e.redir));
        chk("wb_valid", 64'(bus.wb_valid), 64'(e.wb));
        chk("misalign", 64'(bus.misalign), 64'(e.mal));
        chk("br_cnt", 64'(bus.br_cnt), 64'(exp_br));
        chk("mis_cnt", 64'(bus.mis_cnt), 64'(exp_mis));
        if (e.wb)
            chk("wb_link", bus.wb_link, e.link);
        if (e.redir) begin
            for (int k = 0; k < e.hold; k++) begin
                chk("redir_hold_valid", 64'(bus.redir_valid), 64'd1);
                chk("redir_hold_pc", bus.redir_pc, e.rpc);
                chk("redir_hold_in_ready", 64'(bus.in_ready), 64'd0);
                chk("redir_hold_flush", 64'(bus.flush), 64'd0);
                @(negedge clock);
            end
            bus.redir_ready = 1'b1;
            #1;
            chk("handshake_pc", bus.redir_pc, e.rpc);
            chk("handshake_flush", 64'(bus.flush), 64'd1);
            chk("handshake_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clock);
            bus.redir_ready = 1'b0;
            chk("post_redir_valid", 64'(bus.redir_valid), 64'd0);
            chk("post_flush", 64'(bus.flush), 64'd0);
            chk("post_in_ready", 64'(bus.in_ready), 64'd1);
        end else begin
            chk("no_redir_in_ready", 64'(bus.in_ready), 64'd1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_redir_valid"}, 64'(bus.redir_valid), 64'd0);
        chk({tag, "_flush"}, 64'(bus.flush), 64'd0);
        chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd0);
        chk({tag, "_misalign"}, 64'(bus.misalign), 64'd0);
        chk({tag, "_redir_pc"}, bus.redir_pc, 64'd0);
        chk({tag, "_wb_link"}, bus.wb_link, 64'd0);
        chk({tag, "_br_cnt"}, 64'(bus.br_cnt), 64'd0);
        chk({tag, "_mis_cnt"}, 64'(bus.mis_cnt), 64'd0);
    endtask

    initial begin
        //        bt     f3     pc                      imm                     rs1       eq lt pt ptgt      hold redir rpc      wb link      mal
        v[0]  = '{2'b00, 3'b000, 64'h1000,              64'h40,                 64'h0,    1, 0, 0, 64'h0,    3,   1, 64'h1040, 0, 64'h0,    0};
        v[1]  = '{2'b00, 3'b110, 64'h2000,              64'h10,                 64'h0,    0, 0, 0, 64'h0,    0,   0, 64'h0,    0, 64'h0,    0};
        v[2]  = '{2'b00, 3'b001, 64'h2004,              64'h20,                 64'h0,    0, 0, 1, 64'h2024, 0,   0, 64'h0,    0, 64'h0,    0};
        v[3]  = '{2'b10, 3'b000, 64'h3000,              64'h5,                  64'h2003, 0, 0, 1, 64'h2008, 0,   0, 64'h0,    1, 64'h3004, 0};
        v[4]  = '{2'b10, 3'b000, 64'h3004,              64'h7,                  64'h2003, 0, 0, 1, 64'h200A, 0,   0, 64'h0,    1, 64'h3008, 1};
        v[5]  = '{2'b01, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8,                64'h0,    0, 0, 0, 64'h0,    0,   1, 64'h4,    1, 64'h0,    0};
        v[6]  = '{2'b11, 3'b000, 64'h5000,              64'h10,                 64'h0,    1, 1, 1, 64'h5010, 0,   0, 64'h0,    0, 64'h0,    0};
        v[7]  = '{2'b00, 3'b101, 64'h6000,              64'h80,                 64'h0,    0, 1, 1, 64'h1234, 1,   1, 64'h6004, 0, 64'h0,    0};
        v[8]  = '{2'b00, 3'b100, 64'h6000,              64'h80,                 64'h0,    0, 1, 1, 64'h6100, 0,   1, 64'h6080, 0, 64'h0,    0};
        v[9]  = '{2'b00, 3'b010, 64'h7000,              64'h40,                 64'h0,    1, 1, 0, 64'hDEAD, 0,   0, 64'h0,    0, 64'h0,    0};
        v[10] = '{2'b00, 3'b111, 64'h7100,              64'hFFFF_FFFF_FFFF_FF00, 64'h0,   0, 0, 1, 64'h7000, 0,   0, 64'h0,    0, 64'h0,    0};
        v[11] = '{2'b00, 3'b000, 64'h8000,              64'h42,                 64'h0,    1, 0, 1, 64'h8042, 0,   0, 64'h0,    0, 64'h0,    1};
        v[12] = '{2'b01, 3'b000, 64'h9000,              64'h100,                64'h0,    0, 0, 1, 64'h9100, 0,   0, 64'h0,    1, 64'h9004, 0};

        bus.in_valid = 1'b0; bus.br_type = 2'b11; bus.funct3 = 3'b000;
        bus.pc = '0; bus.imm = '0; bus.rs1 = '0; bus.eq_flag = 1'b0; bus.less_flag = 1'b0;
        bus.pred_taken = 1'b0; bus.pred_target = '0; bus.redir_ready = 1'b0;
        sb.in_valid = 1'b0; sb.br_type = 2'b01; sb.funct3 = 3'b000;
        sb.pc = '0; sb.imm = 64'h2; sb.rs1 = '0; sb.eq_flag = 1'b0; sb.less_flag = 1'b0;
        sb.pred_taken = 1'b1; sb.pred_target = 64'h2; sb.redir_ready = 1'b0;

        repeat (2) @(negedge clock);
        check_reset_state("reset");
        reset = 1'b1;

        @(negedge clock);
        drive(v[0]);
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            check_out();
            if (i < NV - 1)
                drive(v[i + 1]);
        end

        @(negedge clock);
        drive(v[0]);
        @(negedge clock);
        bus.in_valid = 1'b0;
        void'(sbq.pop_front());
        chk("mid_redir_valid", 64'(bus.redir_valid), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("mid_redir_reset");
        reset = 1'b1;
        @(negedge clock);
        chk("after_reset_flush", 64'(bus.flush), 64'd0);
        chk("after_reset_redir_valid", 64'(bus.redir_valid), 64'd0);

        sb.in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("sat_br_cnt", 64'(sb.br_cnt), 64'(k > 3 ? 3 : k));
            chk("sat_mis_cnt", 64'(sb.mis_cnt), 64'(k > 3 ? 3 : k));
            chk("sat_misalign", 64'(sb.misalign), 64'd1);
            chk("sat_redir_valid", 64'(sb.redir_valid), 64'd0);
        end
        sb.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch/jump resolution unit of the 64-bit core. It consumes `eq_flag`/`less_flag` from the execute comparator plus the decoded control-transfer fields, decides taken/not-taken, computes the real target, and checks it against the fetch prediction. On a mismatch it holds a redirect request to fetch until accepted, pulses `flush` on acceptance, and keeps saturating branch and mispredict statistics counters.

## Interface
- `XLEN`, 64, datapath width (`REG_BUS`)
- `CNT_W`, 32, statistics counter width
- `clock`  in  1  core clock
- `reset`  in  1  synchronous, active-low reset
- `in_valid`  in  1  control-transfer instruction presented
- `in_ready`  out  1  unit can accept the instruction this cycle
- `br_type`  in  2  00 conditional branch, 01 jal, 10 jalr, 11 none
- `funct3`  in  3  branch condition (RV64I encoding)
- `pc`  in  XLEN  instruction PC
- `imm`  in  XLEN  sign-extended immediate
- `rs1`  in  XLEN  rs1 value (jalr base)
- `eq_flag`  in  1  comparator: op1 == op2
- `less_flag`  in  1  comparator: op1 < op2; upstream sets unsigned mode for BLTU/BGEU
- `pred_taken`  in  1  fetch prediction: taken
- `pred_target`  in  XLEN  fetch predicted target
- `redir_valid`  out  1  redirect request pending
- `redir_ready`  in  1  fetch accepts redirect
- `redir_pc`  out  XLEN  correct next PC
- `flush`  out  1  squash younger instructions (= `redir_valid & redir_ready`)
- `wb_valid`  out  1  link result valid (jal/jalr), one-cycle pulse
- `wb_link`  out  XLEN  pc + 4
- `misalign`  out  1  taken target bit 1 set, one-cycle pulse
- `br_cnt`  out  CNT_W  accepted control transfers, saturating
- `mis_cnt`  out  CNT_W  mispredicts, saturating

## Operation
- States: RUN, REDIR. `in_ready` = (state == RUN).
- Accept = `in_valid & in_ready`. Inputs are sampled only on accept.
- Taken:
  - br_type 00: funct3 000 eq; 001 !eq; 100/110 less; 101/111 !less; 010/011 not taken, `misalign` stays 0.
  - br_type 01/10: always taken.
  - br_type 11: not taken, no counters change, no outputs.
- Target: 00/01 → pc+imm; 10 → (rs1+imm) & ~1. Not taken → pc+4. All arithmetic is modulo 2^XLEN, wrap silently.
- Mispredict = taken != pred_taken, or taken & target != pred_target. A not-taken branch with pred_taken=0 never mispredicts regardless of `pred_target`.
- Taken target with bit 1 = 1:
  - `misalign` pulses and `mis_cnt` increments.
  - No redirect; state stays RUN. The trap path owns recovery.
- Mispredict without misalign:
  - `redir_pc` = correct next PC, `redir_valid` = 1, state → REDIR.
  - `redir_pc` is held stable until the handshake completes.
- REDIR → RUN on `redir_ready`. In that same cycle `flush` = 1 and `redir_valid` drops the next cycle.
- jal/jalr: `wb_valid` pulses with `wb_link` = pc+4 whether or not a mispredict occurs.
- Counters:
  - `br_cnt` +1 per accept with br_type != 11.
  - `mis_cnt` +1 per mispredict or misalign.
  - Both hold at all-ones.

## Timing
- Reset (`reset`=0 at a clock edge): state RUN, and `redir_valid`, `flush`, `wb_valid`, `misalign`, `redir_pc`, `wb_link`, `br_cnt`, `mis_cnt` all 0. Reset mid-REDIR drops the pending redirect without `flush`.
- Accept at edge N: `redir_valid`/`wb_valid`/`misalign` and counter updates are visible after edge N (latency 1).
- A redirect with `redir_ready` already high is held for exactly 1 cycle, with `flush` high in that cycle.
- `in_ready` is 0 for every cycle in REDIR, including the handshake cycle. The next accept is possible at the edge after the handshake.
- Back-to-back correctly predicted instructions: 1 per cycle, no bubbles.
- `redir_valid` never deasserts without `redir_ready`.

## Test plan
- BEQ, pc=0x1000, imm=0x40, eq=1, pred_taken=0 → next cycle `redir_valid`=1, `redir_pc`=0x1040. With `redir_ready` low 3 cycles: held, `in_ready`=0. Then ready=1 → `flush`=1 for one cycle, `mis_cnt`=1, `br_cnt`=1.
- BLTU, less=0, pred_taken=0, back-to-back with BNE, eq=0, pred_taken=1, pred_target=pc+imm → no redirect, `br_cnt`=2, `mis_cnt`=0, `in_ready` high throughout.
- jalr, rs1=0x2003, imm=0x5, pred_target=0x2008 → target 0x2008, no redirect, `wb_valid`=1 with `wb_link`=pc+4. Repeat with imm=0x7 → target 0x200A, `misalign`=1, no redirect.
- jal, pc=0xFFFF_FFFF_FFFF_FFFC, imm=0x8, pred_taken=0 → `redir_pc`=0x4 (wrap), `wb_link`=0x0.
- Mispredict, then `reset`=0 while in REDIR → all outputs 0 and `in_ready`=1 after reset, no `flush`. Also: counters preset to all-ones by 2^32 mispredicts (or forced) stay at all-ones.
